// File: rtl/aoc4_grid_loader.sv
// Converts an ASCII grid stream into TX_DATA_WIDTH-bit row-chunk write packets
// ('@' = 1) and drives them out under the mem_ack/mem_busy handshake.
module aoc4_grid_loader #(
    parameter int TX_DATA_WIDTH = 32,
    parameter int MAX_COLS      = 140,
    parameter int MAX_ROWS      = 140,
    localparam int CAW          = $clog2(MAX_COLS),
    localparam int RAW          = $clog2(MAX_ROWS)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     char_valid_in,
    input  logic [7:0]               char_in,
    input  logic                     eof_in,
    output logic                     char_ready_out,
    output logic                     pad_en_out,
    output logic                     write_en_out,
    output logic                     read_en_out,
    output logic [TX_DATA_WIDTH-1:0] partial_vec_out,
    output logic [RAW-1:0]           row_addr_out,
    output logic [CAW-1:0]           col_addr_out,
    output logic                     staging_out,
    input  logic                     mem_ack_in,
    input  logic                     mem_busy_in,
    output logic [RAW:0]             rows_out,
    output logic                     err_out,
    output logic [1:0]               state_out
);

    localparam int OW = (TX_DATA_WIDTH > 1) ? $clog2(TX_DATA_WIDTH) : 1;
    localparam int CW = CAW + 1;  // column counter must be able to reach MAX_COLS
    localparam int RW = RAW + 1;
    localparam logic [CW-1:0] TX_C      = CW'(TX_DATA_WIDTH);
    localparam logic [CW-1:0] COL_LIMIT = CW'(MAX_COLS);
    localparam logic [RW-1:0] ROW_LIMIT = RW'(MAX_ROWS);

    typedef enum logic [1:0] {
        ST_ACCEPT  = 2'd0,
        ST_WRITE   = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                   state;
    logic                     started;
    logic                     flushed;
    logic                     lf_write;
    logic                     flushing;
    logic                     err_q;
    logic                     write_en_q;
    logic [CW-1:0]            col_q;
    logic [CAW-1:0]           col_addr_q;
    logic [RW-1:0]            row_q;
    logic [TX_DATA_WIDTH-1:0] vec_q;

    logic [OW-1:0] col_off;
    logic [CW-1:0] chunk_base;
    logic          is_cr;
    logic          is_lf;
    logic          is_data;
    logic          overflow;
    logic          at_boundary;
    logic          hold_byte;

    assign col_off     = OW'(col_q % TX_C);
    assign chunk_base  = ((col_q - CW'(1)) / TX_C) * TX_C;
    assign is_cr       = (char_in == 8'd13);
    assign is_lf       = (char_in == 8'd10);
    assign is_data     = !is_cr && !is_lf;
    assign overflow    = (col_q == COL_LIMIT) || (row_q == ROW_LIMIT);
    // flushed marks that the full chunk ending at col_q has already been written
    assign at_boundary = (col_off == '0) && (col_q != '0) && !flushed;
    assign hold_byte   = started && (state == ST_ACCEPT) && char_valid_in && is_data
                         && !overflow && at_boundary;

    // Handshake: a byte (char_valid_in) or eof (eof_in with char_valid_in=0) is taken on
    // the posedge where char_ready_out=1; a byte that must wait for a chunk write sees
    // ready low and stays on the bus until ready returns.
    assign char_ready_out  = started && (state == ST_ACCEPT) && !hold_byte;
    assign write_en_out    = write_en_q;
    assign pad_en_out      = write_en_q;
    assign read_en_out     = 1'b0;
    assign partial_vec_out = vec_q;
    assign row_addr_out    = row_q[RAW-1:0];
    assign col_addr_out    = col_addr_q;
    assign rows_out        = row_q;
    assign err_out         = err_q;
    assign staging_out     = (state != ST_DONE);
    assign state_out       = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_ACCEPT;
            started    <= 1'b0;
            flushed    <= 1'b0;
            lf_write   <= 1'b0;
            flushing   <= 1'b0;
            err_q      <= 1'b0;
            write_en_q <= 1'b0;
            col_q      <= '0;
            col_addr_q <= '0;
            row_q      <= '0;
            vec_q      <= '0;
        end else begin
            started <= 1'b1;
            case (state)
                ST_ACCEPT: begin
                    if (char_ready_out && char_valid_in) begin
                        if (is_data) begin
                            if (overflow) begin
                                err_q <= 1'b1;
                            end else begin
                                vec_q[col_off] <= (char_in == 8'h40);
                                col_q          <= col_q + CW'(1);
                                flushed        <= 1'b0;
                            end
                        end else if (is_lf && (col_q != '0)) begin
                            if (flushed) begin
                                col_q   <= '0;
                                row_q   <= row_q + RW'(1);
                                flushed <= 1'b0;
                            end else begin
                                state      <= ST_WRITE;
                                write_en_q <= 1'b1;
                                col_addr_q <= CAW'(chunk_base);
                                lf_write   <= 1'b1;
                            end
                        end
                    end else if (hold_byte) begin
                        state      <= ST_WRITE;
                        write_en_q <= 1'b1;
                        col_addr_q <= CAW'(col_q - TX_C);
                        lf_write   <= 1'b0;
                    end else if (char_ready_out && eof_in) begin
                        if ((col_q != '0) && !flushed) begin
                            state      <= ST_WRITE;
                            write_en_q <= 1'b1;
                            col_addr_q <= CAW'(chunk_base);
                            lf_write   <= 1'b1;
                            flushing   <= 1'b1;
                        end else begin
                            if (col_q != '0) begin
                                col_q <= '0;
                                row_q <= row_q + RW'(1);
                            end
                            state <= ST_DONE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (mem_ack_in) begin
                        write_en_q <= 1'b0;
                        vec_q      <= '0;
                        if (lf_write) begin
                            col_q   <= '0;
                            row_q   <= row_q + RW'(1);
                            flushed <= 1'b0;
                        end else begin
                            flushed <= 1'b1;
                        end
                        if (mem_busy_in)   state <= ST_RELEASE;
                        else if (flushing) state <= ST_DONE;
                        else               state <= ST_ACCEPT;
                    end
                end
                ST_RELEASE: begin
                    if (!mem_ack_in) state <= flushing ? ST_DONE : ST_ACCEPT;
                end
                ST_DONE: begin
                end
            endcase
        end
    end

endmodule
